matrix_scan_driver: RTL
=======================

Name: matrix_scan_driver

Overview:
- Display-side reader of the 8x16 snake pixel bitmap produced by the pixel generator.
- Latches a frame snapshot once per scan, then row-multiplexes it onto an LED matrix: one row at a time, with a blanking gap between rows to suppress ghosting.
- Sits between the game-logic pixel register and the board's row/column pins.

Parameters:
- ROWS, 8, number of matrix rows; row r is bits [16r+15:16r] of pixel_reg.
- COLS, 16, number of columns; column c of a row is bit c of that row slice.
- DWELL_CYCLES, 1024, clocks a row is driven; must be >= 2.
- BLANK_CYCLES, 16, clocks all rows and columns are off before each row; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low forces blanking and row 0.
- pixel_reg  in  ROWS*COLS  bitmap; bit value 0 = lit.
- brightness  in  4  PWM duty code; used only with the optional feature, otherwise ignored.
- row_sel  out  ROWS  one-hot row drive, active-high.
- col_n  out  COLS  column drive, active-low (0 = LED on).
- row_idx  out  3  index of the row currently driven or about to be driven.
- frame_start  out  1  one-cycle pulse when a new snapshot is latched.

Behaviour:
- All outputs registered. Reset (async) values:
  - row_sel = 0, col_n = all 1s, row_idx = 0, frame_start = 0.
  - State = BLANK, counter = 0, snapshot = all 1s.
- FSM has two states, BLANK and DRIVE.
- BLANK:
  - row_sel = 0, col_n = all 1s.
  - Counter runs 0..BLANK_CYCLES-1, then clears; next state is DRIVE.
- Snapshot and frame_start:
  - On the first BLANK cycle with row_idx = 0, pixel_reg is copied into the snapshot.
  - frame_start = 1 on the cycle after that edge, for exactly 1 cycle.
  - pixel_reg changes at any other time do not affect the frame in progress (no tearing).
- DRIVE:
  - row_sel = 1 << row_idx; col_n = snapshot row slice [row_idx].
  - Counter runs 0..DWELL_CYCLES-1.
  - On the last count: row_idx <= (row_idx == ROWS-1) ? 0 : row_idx+1, counter clears, state = BLANK.
- Timing:
  - Row period = BLANK_CYCLES + DWELL_CYCLES.
  - Frame period = ROWS * (BLANK_CYCLES + DWELL_CYCLES).
  - Defaults: 8320 clocks per frame.
- enable low (any state, any count):
  - Next edge: state = BLANK, counter = 0, row_idx = 0, row_sel = 0, col_n = all 1s.
  - No snapshot is taken and no frame_start pulses while enable is low.
  - After enable rises, the first BLANK cycle takes a fresh snapshot; the scan restarts at row 0.
- row_sel is never non-zero in the same cycle as a row change. There is always at least BLANK_CYCLES of all-off between rows.
- rst mid-row: outputs go off immediately (async) and the scan restarts from row 0 with a new snapshot.
- Counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)). Wrap is by explicit compare, never natural overflow.

Optional Feature:
- Macro: MATRIX_SCAN_BRIGHTNESS_PWM_EN.
- With the macro, during DRIVE:
  - col_n = row slice when counter < ((brightness+1)*DWELL_CYCLES) >> 4, else all 1s.
  - The product is computed at counter width + 5 bits.
  - brightness = 15 gives full dwell; brightness = 0 gives DWELL_CYCLES/16.
  - brightness is sampled at DRIVE entry and held for that row.
- Without the macro, brightness is unconnected internally and columns are driven for the full dwell.
- row_sel timing is identical in both builds.

Decomposition:
- Shared header snake_defs.vh holds:
  - ROWS, COLS, PIXEL_W = ROWS*COLS.
  - PIXEL_LIT = 1'b0.
  - State encodings ST_BLANK = 1'b0, ST_DRIVE = 1'b1.
- The pixel generator also uses ROWS, COLS, PIXEL_W and PIXEL_LIT.
- One sub-module, scan_timer:
  - Parameterised down-counter taking a load value.
  - Outputs a terminal-count pulse.
  - Instantiated once and reloaded with BLANK_CYCLES or DWELL_CYCLES on each state change.

Test Plan:
- Reset then enable=1, pixel_reg = all 1s except row 0 bit 0 = 0:
  - frame_start pulses once.
  - After 16 clocks row_sel = 8'h01 and col_n = 16'hFFFE for 1024 clocks.
  - Then 16 clocks of row_sel = 0.
- Full scan with defaults:
  - row_sel steps 01,02,...,80 then back to 01.
  - frame_start pulses every 8320 clocks.
  - Never two row_sel bits set; never row_sel != 0 during BLANK.
- Change pixel_reg row 3 to 16'h0000 while row 1 is driving:
  - Row 3 still shows the old value this frame.
  - Row 3 shows 16'h0000 the next frame.
- Deassert enable during DRIVE of row 5:
  - Next clock row_sel = 0, col_n = 16'hFFFF, row_idx = 0.
  - On re-enable, frame_start pulses and the scan resumes at row 0.
- Assert rst mid-DRIVE:
  - row_sel = 0 and col_n = 16'hFFFF without waiting for a clock edge.
  - After release, timing matches the first scenario.
- With MATRIX_SCAN_BRIGHTNESS_PWM_EN and brightness = 3:
  - Columns are lit for the first 256 of 1024 dwell clocks, off for the remaining 768.
  - row_sel stays high for all 1024.

Source files
------------

// File: rtl/matrix_scan_driver_pkg.sv
// Shared constants and state encoding for the LED matrix scan path.
// The pixel generator uses the same geometry and lit polarity.
package matrix_scan_driver_pkg;

  localparam int DEF_ROWS    = 8;
  localparam int DEF_COLS    = 16;
  localparam int DEF_PIXEL_W = DEF_ROWS * DEF_COLS;

  // A pixel bit of 0 means the LED is on; col_n uses the same polarity.
  localparam logic PIXEL_LIT = 1'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// Loadable down-counter for row blank/dwell timing; o_tc is high while the
// count sits at zero, which the owner turns into a pulse by reloading.
module scan_timer
  import matrix_scan_driver_pkg::*;
#(
  parameter int           W         = 10,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_load) begin
      w_count_next = i_load_val;
    end else if (r_count != '0) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_tc         = (r_count == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix driver: snapshots the pixel bitmap once per
// frame and drives one row at a time with a blanking gap before each row.
// Optional per-row PWM dimming: define MATRIX_SCAN_BRIGHTNESS_PWM_EN.
module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int  ROWS         = DEF_ROWS,
  parameter int  COLS         = DEF_COLS,
  parameter int  DWELL_CYCLES = 1024,
  parameter int  BLANK_CYCLES = 16,
  localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] pixel_reg,
  input  logic [3:0]           brightness,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_n,
  output logic [RW-1:0]        row_idx,
  output logic                 frame_start
);

  localparam int             CW         = $clog2(max2(DWELL_CYCLES, BLANK_CYCLES));
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [COLS-1:0] COLS_OFF  = {COLS{~PIXEL_LIT}};

  scan_state_t           r_state, w_state_next;
  logic [RW-1:0]         r_row_idx, w_row_idx_next;
  logic [ROWS*COLS-1:0]  r_snapshot;
  logic [ROWS-1:0]       r_row_sel;
  logic [COLS-1:0]       r_col_n;
  logic                  r_frame_start;

  logic                  w_load;
  logic [CW-1:0]         w_load_val;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_next;
  logic                  w_tc;
  logic                  w_snap_take;
  logic [ROWS*COLS-1:0]  w_frame_src;
  logic [COLS-1:0]       w_rows [ROWS];
  logic [ROWS-1:0]       w_row_onehot;
  logic [COLS-1:0]       w_row_slice;
  logic                  w_cols_lit;

  scan_timer #(
    .W         (CW),
    .RESET_VAL (BLANK_LAST)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_tc         (w_tc)
  );

  always_comb begin
    w_state_next   = r_state;
    w_row_idx_next = r_row_idx;
    w_load         = 1'b0;
    w_load_val     = BLANK_LAST;
    if (!enable) begin
      w_state_next   = ST_BLANK;
      w_row_idx_next = '0;
      w_load         = 1'b1;
    end else if (w_tc) begin
      w_load = 1'b1;
      if (r_state == ST_BLANK) begin
        w_state_next = ST_DRIVE;
        w_load_val   = DWELL_LAST;
      end else begin
        w_state_next   = ST_BLANK;
        w_row_idx_next = (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
      end
    end
  end

  // The timer is loaded with BLANK_LAST on entry, so that count marks the first blank cycle.
  assign w_snap_take = enable && (r_state == ST_BLANK) && (r_row_idx == '0)
                       && (w_count == BLANK_LAST);
  assign w_frame_src = w_snap_take ? pixel_reg : r_snapshot;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign w_rows[gi]       = w_frame_src[gi*COLS +: COLS];
    assign w_row_onehot[gi] = (w_row_idx_next == RW'(gi));
  end

  assign w_row_slice = w_rows[w_row_idx_next];

`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0]    r_bright;
  logic [3:0]    w_bright_eff;
  logic [CW+4:0] w_product;
  logic [CW+4:0] w_on_limit;
  logic [CW-1:0] w_elapsed_next;

  // Brightness is captured on DRIVE entry and held for the whole row.
  assign w_bright_eff   = (r_state == ST_BLANK && w_state_next == ST_DRIVE) ? brightness : r_bright;
  assign w_product      = ({{(CW+1){1'b0}}, w_bright_eff} + (CW+5)'(1)) * (CW+5)'(DWELL_CYCLES);
  assign w_on_limit     = w_product >> 4;
  assign w_elapsed_next = DWELL_LAST - w_count_next;
  assign w_cols_lit     = ({5'b0, w_elapsed_next} < w_on_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else begin
      r_bright <= w_bright_eff;
    end
  end
`else
  logic w_unused;
  assign w_unused   = ^{brightness, w_count_next};
  assign w_cols_lit = 1'b1;
`endif

  // Outputs are computed from next-state values so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_row_idx     <= '0;
      r_snapshot    <= '1;
      r_row_sel     <= '0;
      r_col_n       <= COLS_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_row_idx     <= w_row_idx_next;
      r_frame_start <= w_snap_take;
      if (w_snap_take) begin
        r_snapshot <= pixel_reg;
      end
      if (w_state_next == ST_DRIVE) begin
        r_row_sel <= w_row_onehot;
        r_col_n   <= w_cols_lit ? w_row_slice : COLS_OFF;
      end else begin
        r_row_sel <= '0;
        r_col_n   <= COLS_OFF;
      end
    end
  end

  assign row_sel     = r_row_sel;
  assign col_n       = r_col_n;
  assign row_idx     = r_row_idx;
  assign frame_start = r_frame_start;

endmodule
